// File: rtl/key_entry_fsm.sv
// Keypad entry controller: builds signed decimal entries, sequences operand/operator
// latching, fires the calculator and holds the value for the segment display.
module key_entry_fsm #(
  parameter int unsigned CALC_LAT = 2,
  parameter int unsigned MAX_MAG  = 2147483647
) (
  input  logic        sw_clk,
  input  logic        rst_n,
  input  logic [3:0]  eBCD,
  input  logic        key_valid,
  input  logic [31:0] result,
  input  logic        calc_err,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  output logic [2:0]  operator,
  output logic        start,
  output logic [31:0] fnd_serial,
  output logic        err_flag
);

  localparam int unsigned CntW = $clog2(CALC_LAT + 2);

  typedef enum logic [2:0] {
    StIdleA, StEnterA, StOpWait, StEnterB, StCalc, StShow
  } state_e;

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic [30:0]      mag_q, mag_d;
  logic [31:0]      operand1_q, operand1_d;
  logic [31:0]      operand2_q, operand2_d;
  logic [2:0]       operator_q, operator_d;
  logic [2:0]       pend_op_q, pend_op_d;
  logic             chain_q, chain_d;
  logic             start_q, start_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [31:0]      fnd_q, fnd_d;
  logic             err_q, err_d;

  logic        is_digit, is_op, is_eq, is_neg;
  logic [3:0]  op_off;
  logic [2:0]  op_code;
  logic [34:0] app_sum;
  logic        app_ok;
  logic [31:0] buf_val;

  function automatic logic [31:0] signed_val(input logic sign, input logic [30:0] mag);
    return sign ? (32'd0 - {1'b0, mag}) : {1'b0, mag};
  endfunction

  assign is_digit = key_valid && (eBCD <= 4'd9);
  assign is_op    = key_valid && (eBCD >= 4'd10) && (eBCD <= 4'd13);
  assign is_eq    = key_valid && (eBCD == 4'd14);
  assign is_neg   = key_valid && (eBCD == 4'd15);
  assign op_off   = eBCD - 4'd10;
  assign op_code  = {1'b0, op_off[1:0]};

  // Wide enough that mag*10+d can never wrap before the range check.
  assign app_sum  = ({4'd0, mag_q} * 35'd10) + {31'd0, eBCD};
  assign app_ok   = app_sum <= 35'(MAX_MAG);
  assign buf_val  = signed_val(sign_q, mag_q);

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    operand1_d = operand1_q;
    operand2_d = operand2_q;
    operator_d = operator_q;
    pend_op_d  = pend_op_q;
    chain_d    = chain_q;
    start_d    = 1'b0;
    cnt_d      = cnt_q;
    err_d      = err_q;

    unique case (state_q)
      StIdleA: begin
        if (is_digit) begin
          sign_d  = 1'b0;
          mag_d   = {27'd0, eBCD};
          state_d = StEnterA;
        end else if (is_neg) begin
          sign_d  = 1'b1;
          mag_d   = '0;
          state_d = StEnterA;
        end
      end
      StEnterA: begin
        if (is_digit) begin
          if (app_ok) mag_d = app_sum[30:0];
        end else if (is_neg) begin
          sign_d = ~sign_q;
        end else if (is_op) begin
          operand1_d = buf_val;
          operator_d = op_code;
          state_d    = StOpWait;
        end else if (is_eq) begin
          operand1_d = buf_val;
          state_d    = StShow;
        end
      end
      StOpWait: begin
        if (is_op) begin
          operator_d = op_code;
        end else if (is_digit) begin
          sign_d  = 1'b0;
          mag_d   = {27'd0, eBCD};
          state_d = StEnterB;
        end else if (is_neg) begin
          sign_d  = 1'b1;
          mag_d   = '0;
          state_d = StEnterB;
        end
      end
      StEnterB: begin
        if (is_digit) begin
          if (app_ok) mag_d = app_sum[30:0];
        end else if (is_neg) begin
          sign_d = ~sign_q;
        end else if (is_eq || is_op) begin
          operand2_d = buf_val;
          chain_d    = is_op;
          if (is_op) pend_op_d = op_code;
          start_d    = 1'b1;
          cnt_d      = '0;
          state_d    = StCalc;
        end
      end
      StCalc: begin
        // Counting starts with the start cycle; capture at the end of cycle CALC_LAT after it.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(CALC_LAT)) begin
          if (calc_err) begin
            err_d   = 1'b1;
            state_d = StShow;
          end else begin
            operand1_d = result;
            if (chain_q) begin
              operator_d = pend_op_q;
              state_d    = StOpWait;
            end else begin
              state_d = StShow;
            end
          end
        end
      end
      StShow: begin
        if (is_digit) begin
          err_d   = 1'b0;
          sign_d  = 1'b0;
          mag_d   = {27'd0, eBCD};
          state_d = StEnterA;
        end else if (is_neg) begin
          err_d   = 1'b0;
          sign_d  = 1'b1;
          mag_d   = '0;
          state_d = StEnterA;
        end else if (is_op && !err_q) begin
          operator_d = op_code;
          state_d    = StOpWait;
        end else if (is_eq && !err_q) begin
          chain_d = 1'b0;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      default: state_d = StIdleA;
    endcase
  end

  always_comb begin
    fnd_d = fnd_q;
    unique case (state_d)
      StIdleA:            fnd_d = '0;
      StEnterA, StEnterB: fnd_d = signed_val(sign_d, mag_d);
      StOpWait:           fnd_d = operand1_d;
      StShow:             fnd_d = err_d ? 32'd0 : operand1_d;
      StCalc:             fnd_d = fnd_q;
      default:            fnd_d = '0;
    endcase
  end

  always_ff @(posedge sw_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdleA;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      operand1_q <= '0;
      operand2_q <= '0;
      operator_q <= '0;
      pend_op_q  <= '0;
      chain_q    <= 1'b0;
      start_q    <= 1'b0;
      cnt_q      <= '0;
      fnd_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      operand1_q <= operand1_d;
      operand2_q <= operand2_d;
      operator_q <= operator_d;
      pend_op_q  <= pend_op_d;
      chain_q    <= chain_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      fnd_q      <= fnd_d;
      err_q      <= err_d;
    end
  end

  assign operand1   = operand1_q;
  assign operand2   = operand2_q;
  assign operator   = operator_q;
  assign start      = start_q;
  assign fnd_serial = fnd_q;
  assign err_flag   = err_q;

endmodule

// File: tb/tb_key_entry_fsm.sv
// Directed bench for key_entry_fsm with a fixed-latency calculator model.
module tb_key_entry_fsm;

  logic        sw_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic [3:0]  eBCD   = 4'd0;
  logic        key_valid = 1'b0;
  logic [31:0] result;
  logic        calc_err;
  logic [31:0] operand1, operand2, fnd_serial;
  logic [2:0]  operator;
  logic        start, err_flag;

  logic [31:0] model_res = 32'd0;
  logic        model_err = 1'b0;
  logic [1:0]  pipe = 2'b00;
  int          start_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          s0;

  key_entry_fsm #(.CALC_LAT(2), .MAX_MAG(2147483647)) dut (
    .sw_clk    (sw_clk),
    .rst_n     (rst_n),
    .eBCD      (eBCD),
    .key_valid (key_valid),
    .result    (result),
    .calc_err  (calc_err),
    .operand1  (operand1),
    .operand2  (operand2),
    .operator  (operator),
    .start     (start),
    .fnd_serial(fnd_serial),
    .err_flag  (err_flag)
  );

  always #5 sw_clk = ~sw_clk;

  // Calculator model: result/calc_err valid only in the 2nd cycle after the start cycle.
  always @(posedge sw_clk) begin
    pipe <= {pipe[0], start};
    if (start) start_cnt <= start_cnt + 1;
  end
  assign result   = pipe[1] ? model_res : 32'h5A5A_5A5A;
  assign calc_err = pipe[1] ? model_err : 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, $signed(got), got,
               $signed(exp), exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge sw_clk);
    eBCD      = k;
    key_valid = 1'b1;
    @(negedge sw_clk);
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    key_valid = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge sw_clk);
    rst_n = 1'b1;
    @(negedge sw_clk);
  endtask

  // Called right after the key that enters CALC has been sampled.
  task automatic run_calc(input string tag, input logic [31:0] held, input logic [31:0] exp);
    check({tag, "_start_hi"}, {31'd0, start}, 32'd1);
    @(negedge sw_clk);
    check({tag, "_start_lo"}, {31'd0, start}, 32'd0);
    @(negedge sw_clk);
    check({tag, "_held"}, fnd_serial, held);
    @(negedge sw_clk);
    check({tag, "_fnd"}, fnd_serial, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] max_digits [10];
    max_digits = '{4'd2, 4'd1, 4'd4, 4'd7, 4'd4, 4'd8, 4'd3, 4'd6, 4'd4, 4'd7};

    do_reset();
    check("rst_op1", operand1, 32'd0);
    check("rst_op2", operand2, 32'd0);
    check("rst_opr", {29'd0, operator}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_fnd", fnd_serial, 32'd0);
    check("rst_err", {31'd0, err_flag}, 32'd0);

    // 12 + 34 = 46
    s0 = start_cnt;
    press(4'hA);
    check("t1_idle_op_ignored", fnd_serial, 32'd0);
    press(4'd1);
    check("t1_fnd1", fnd_serial, 32'd1);
    press(4'd2);
    check("t1_fnd12", fnd_serial, 32'd12);
    press(4'hA);
    check("t1_op1", operand1, 32'd12);
    check("t1_opr", {29'd0, operator}, 32'd0);
    press(4'd3);
    press(4'd4);
    check("t1_fnd34", fnd_serial, 32'd34);
    model_res = 32'd46;
    press(4'hE);
    check("t1_op2", operand2, 32'd34);
    run_calc("t1", 32'd34, 32'd46);
    check("t1_starts", 32'(start_cnt - s0), 32'd1);

    // -7 * 5 = -35, then '=' again gives -175
    press(4'hF);
    check("t2_neg0", fnd_serial, 32'd0);
    press(4'd7);
    check("t2_fnd_m7", fnd_serial, 32'hFFFF_FFF9);
    press(4'hC);
    check("t2_op1", operand1, 32'hFFFF_FFF9);
    check("t2_opr", {29'd0, operator}, 32'd2);
    press(4'd5);
    model_res = 32'hFFFF_FFDD;
    press(4'hE);
    run_calc("t2a", 32'd5, 32'hFFFF_FFDD);
    check("t2_op1_res", operand1, 32'hFFFF_FFDD);
    model_res = 32'hFFFF_FF51;
    press(4'hE);
    check("t2_rerun_op2", operand2, 32'd5);
    run_calc("t2b", 32'hFFFF_FFDD, 32'hFFFF_FF51);

    // Chain: 9 - 4 = 5, then + 2 = 7
    s0 = start_cnt;
    press(4'd9);
    check("t3_fnd9", fnd_serial, 32'd9);
    press(4'hB);
    check("t3_opr_sub", {29'd0, operator}, 32'd1);
    press(4'd4);
    model_res = 32'd5;
    press(4'hA);
    run_calc("t3a", 32'd4, 32'd5);
    check("t3_chain_opr", {29'd0, operator}, 32'd0);
    check("t3_chain_op1", operand1, 32'd5);
    press(4'd2);
    check("t3_fnd2", fnd_serial, 32'd2);
    model_res = 32'd7;
    press(4'hE);
    run_calc("t3b", 32'd2, 32'd7);
    check("t3_starts", 32'(start_cnt - s0), 32'd2);

    // Magnitude limit
    foreach (max_digits[i]) press(max_digits[i]);
    check("t4_max", fnd_serial, 32'd2147483647);
    press(4'd1);
    check("t4_max_drop", fnd_serial, 32'd2147483647);
    press(4'hA);
    for (int i = 0; i < 9; i++) press(max_digits[i]);
    check("t4_9dig", fnd_serial, 32'd214748364);
    press(4'd8);
    check("t4_8_drop", fnd_serial, 32'd214748364);
    press(4'd7);
    check("t4_7_ok", fnd_serial, 32'd2147483647);

    // Divide by zero -> sticky error
    do_reset();
    press(4'd8);
    press(4'hD);
    check("t5_opr_div", {29'd0, operator}, 32'd3);
    press(4'd0);
    model_res = 32'd99;
    model_err = 1'b1;
    press(4'hE);
    run_calc("t5", 32'd0, 32'd0);
    check("t5_err", {31'd0, err_flag}, 32'd1);
    model_err = 1'b0;
    press(4'hA);
    check("t5_op_ignored", {29'd0, operator}, 32'd3);
    check("t5_err_held", {31'd0, err_flag}, 32'd1);
    press(4'hE);
    check("t5_eq_ignored", {31'd0, start}, 32'd0);
    press(4'd3);
    check("t5_clr_err", {31'd0, err_flag}, 32'd0);
    check("t5_fnd3", fnd_serial, 32'd3);

    // Reset in the middle of CALC
    press(4'hA);
    press(4'd4);
    model_res = 32'd77;
    s0 = start_cnt;
    press(4'hE);
    check("t6_start_hi", {31'd0, start}, 32'd1);
    eBCD      = 4'd5;
    key_valid = 1'b1;
    rst_n     = 1'b0;
    #1;
    check("t6_start_async", {31'd0, start}, 32'd0);
    check("t6_op1", operand1, 32'd0);
    check("t6_op2", operand2, 32'd0);
    check("t6_fnd", fnd_serial, 32'd0);
    repeat (2) @(negedge sw_clk);
    key_valid = 1'b0;
    rst_n     = 1'b1;
    repeat (4) @(negedge sw_clk);
    check("t6_no_capture", fnd_serial, 32'd0);
    check("t6_no_capture_op1", operand1, 32'd0);
    check("t6_no_start", 32'(start_cnt - s0), 32'd0);
    press(4'hE);
    check("t6_idle_eq", {31'd0, start}, 32'd0);
    press(4'd6);
    check("t6_idle_digit", fnd_serial, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
